// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, quarter-wave sine table and a fixed 5-stage pipeline
// producing sine, triangle, square or sawtooth samples scaled by amp.
module dds_wave_gen #(
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned LUT_AW    = 10,
  parameter int unsigned OUT_W     = 16,
  parameter              INIT_FILE = "sin_quarter.hex"
) (
  input  logic              clka,
  input  logic              rstn,
  input  logic              en,
  input  logic              sync_clr,
  input  logic [ACC_W-1:0]  freq_word,
  input  logic [LUT_AW-1:0] phase_off,
  input  logic [1:0]        mode,
  input  logic [OUT_W-1:0]  amp,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_valid,
  output logic              phase_wrap
);

  localparam int unsigned IW = LUT_AW - 2;
  localparam int unsigned N  = 2 ** IW;

  typedef enum logic [1:0] {ModeSine, ModeTri, ModeSquare, ModeSaw} mode_e;

  // Quarter-wave table built at elaboration with the same contents the INIT_FILE image holds.
  function automatic logic [OUT_W-2:0] sin_entry(input int unsigned i);
    real ang;
    real val;
    ang = 1.5707963267948966 * real'(i) / real'(N - 1);
    val = (2.0 ** (OUT_W - 1) - 1.0) * $sin(ang) + 0.5;
    return (OUT_W-1)'($rtoi(val));
  endfunction

  logic [OUT_W-2:0] rom [N];

  for (genvar g = 0; g < N; g++) begin : g_rom
    assign rom[g] = sin_entry(g);
  end

  // Accumulator
  logic [ACC_W-1:0] acc_q;
  logic             phase_wrap_q;
  logic [ACC_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc_q} + {1'b0, freq_word};

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      acc_q        <= '0;
      phase_wrap_q <= 1'b0;
    end else if (sync_clr) begin
      acc_q        <= '0;
      phase_wrap_q <= 1'b0;
    end else if (en) begin
      acc_q        <= acc_sum[ACC_W-1:0];
      phase_wrap_q <= acc_sum[ACC_W];
    end else begin
      phase_wrap_q <= 1'b0;
    end
  end

  // Pipeline registers; mode and amp ride along with each sample.
  logic [LUT_AW-1:0] p1_q, p2_q;
  mode_e             mode1_q, mode2_q;
  logic [OUT_W-1:0]  amp1_q, amp2_q, amp3_q, amp4_q;
  logic              v1_q, v2_q, v3_q, v4_q;
  logic [IW-1:0]     idx2_q;
  logic              neg2_q, neg3_q, saw3_q;
  logic [OUT_W-1:0]  mag3_q, wave4_q;
  logic [OUT_W-1:0]  dout_q;
  logic              dout_valid_q;

  logic [OUT_W-1:0]  mag_d;
  logic [OUT_W-1:0]  saw_ext;
  logic [OUT_W-1:0]  wave_d;

  always_comb begin
    mag_d   = '0;
    saw_ext = OUT_W'({~p2_q[LUT_AW-1], p2_q[LUT_AW-2:0]});
    unique case (mode2_q)
      ModeSine:   mag_d = {1'b0, rom[idx2_q]};
      ModeTri:    mag_d = OUT_W'(idx2_q) << (OUT_W - 1 - IW);
      ModeSquare: mag_d = {1'b0, {(OUT_W-1){1'b1}}};
      ModeSaw:    mag_d = saw_ext << (OUT_W - LUT_AW);
    endcase
  end

  // Sawtooth is already a signed full-scale word; the others are magnitudes below 2^(OUT_W-1).
  always_comb begin
    wave_d = mag3_q;
    if (!saw3_q && neg3_q) begin
      wave_d = -mag3_q;
    end
  end

  logic [2*OUT_W:0] wave_x;
  logic [2*OUT_W:0] amp_x;
  logic [2*OUT_W:0] prod;
  logic             unused_prod;

  assign wave_x      = {{(OUT_W+1){wave4_q[OUT_W-1]}}, wave4_q};
  assign amp_x       = {{(OUT_W+1){1'b0}}, amp4_q};
  assign prod        = wave_x * amp_x;
  assign unused_prod = ^{prod[2*OUT_W], prod[OUT_W-1:0]};

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      p1_q         <= '0;
      mode1_q      <= ModeSine;
      amp1_q       <= '0;
      v1_q         <= 1'b0;
      p2_q         <= '0;
      idx2_q       <= '0;
      neg2_q       <= 1'b0;
      mode2_q      <= ModeSine;
      amp2_q       <= '0;
      v2_q         <= 1'b0;
      mag3_q       <= '0;
      neg3_q       <= 1'b0;
      saw3_q       <= 1'b0;
      amp3_q       <= '0;
      v3_q         <= 1'b0;
      wave4_q      <= '0;
      amp4_q       <= '0;
      v4_q         <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      p1_q         <= acc_q[ACC_W-1 -: LUT_AW] + phase_off;
      mode1_q      <= mode_e'(mode);
      amp1_q       <= amp;
      v1_q         <= en & ~sync_clr;

      idx2_q       <= p1_q[LUT_AW-2] ? ~p1_q[IW-1:0] : p1_q[IW-1:0];
      neg2_q       <= p1_q[LUT_AW-1];
      p2_q         <= p1_q;
      mode2_q      <= mode1_q;
      amp2_q       <= amp1_q;
      v2_q         <= v1_q;

      mag3_q       <= mag_d;
      neg3_q       <= neg2_q;
      saw3_q       <= (mode2_q == ModeSaw);
      amp3_q       <= amp2_q;
      v3_q         <= v2_q;

      wave4_q      <= wave_d;
      amp4_q       <= amp3_q;
      v4_q         <= v3_q;

      dout_valid_q <= v4_q;
      if (v4_q) begin
        dout_q <= prod[2*OUT_W-1:OUT_W];
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign phase_wrap = phase_wrap_q;

endmodule
